// File: rtl/topk_result_collector_if.sv
// Bundle of the stream, host-pop and status signals between the search core, the
// result collector and the UART register bridge.
interface topk_result_collector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_K      = 8
);
    localparam int CW = $clog2(MAX_K + 1);

    logic                  start_in;
    logic [15:0]           k_in;
    logic [DATA_WIDTH-1:0] result_in;
    logic                  result_valid_in;
    logic [31:0]           host_req_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid_out;
    logic [CW-1:0]         count_out;
    logic                  done_out;
    logic                  overflow_out;

    modport master (
        output start_in, k_in, result_in, result_valid_in, host_req_in,
        input  data_out, data_valid_out, count_out, done_out, overflow_out
    );

    modport slave (
        input  start_in, k_in, result_in, result_valid_in, host_req_in,
        output data_out, data_valid_out, count_out, done_out, overflow_out
    );
endinterface

// File: rtl/topk_result_collector.sv
// Captures k result words from the search core after start_in, then serves them one
// per host pop (rising transition of the pop register to 1) with count/done/overflow status.
module topk_result_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_K      = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    topk_result_collector_if.slave     bus
);
    localparam int CW = $clog2(MAX_K + 1);
    localparam int AW = (MAX_K > 1) ? $clog2(MAX_K) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_READY} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         wr_q, wr_d;
    logic [CW-1:0]         rd_q, rd_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         k_q, k_d;
    logic [31:0]           req_q;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  dvalid_q, dvalid_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_en;
    logic                  arm;
    logic                  pop;
    logic [CW-1:0]         k_eff;
    logic [DATA_WIDTH-1:0] mem_q [MAX_K];

    assign k_eff = (bus.k_in > 16'(MAX_K)) ? CW'(MAX_K) : bus.k_in[CW-1:0];
    assign pop   = (bus.host_req_in != req_q) && (bus.host_req_in == 32'd1);

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        count_d  = count_q;
        k_d      = k_q;
        data_d   = data_q;
        dvalid_d = dvalid_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        arm      = 1'b0;

        unique case (state_q)
            S_IDLE: arm = bus.start_in;
            S_COLLECT: begin
                if (bus.result_valid_in) begin
                    wr_en   = 1'b1;
                    wr_d    = wr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_d == k_q) begin
                        state_d  = S_READY;
                        dvalid_d = 1'b1;
                        // With k==1 the head word is the one being written right now.
                        data_d   = (count_q == '0) ? bus.result_in : mem_q[0];
                    end
                end
            end
            S_READY: begin
                if (bus.start_in) begin
                    arm = 1'b1;
                end else begin
                    if (bus.result_valid_in) ovf_d = 1'b1;
                    if (pop && (rd_q < count_q)) begin
                        rd_d = rd_q + 1'b1;
                        if (rd_d < count_q) data_d = mem_q[rd_d[AW-1:0]];
                        else                dvalid_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (arm) begin
            k_d      = k_eff;
            wr_d     = '0;
            rd_d     = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            dvalid_d = 1'b0;
            state_d  = (k_eff == '0) ? S_READY : S_COLLECT;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            k_q      <= '0;
            req_q    <= '0;
            data_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            k_q      <= k_d;
            req_q    <= bus.host_req_in;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the result buffer has no reset; pointers and count guard every read of it.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= bus.result_in;
    end

    assign bus.data_out       = data_q;
    assign bus.data_valid_out = dvalid_q;
    assign bus.count_out      = count_q;
    assign bus.done_out       = (state_q == S_READY);
    assign bus.overflow_out   = ovf_q;
endmodule

// File: tb/tb_topk_result_collector.sv
// Self-checking bench: directed scenarios plus random traffic compared every cycle
// against a queue-based model of the collector.
module tb_topk_result_collector;
    localparam int DW = 32;
    localparam int MK = 8;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    topk_result_collector_if #(.DATA_WIDTH(DW), .MAX_K(MK)) bus ();
    topk_result_collector #(.DATA_WIDTH(DW), .MAX_K(MK)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 idle, 1 collecting, 2 serving.
    int            m_mode;
    int            m_keff;
    int            m_served;
    bit            m_ovf;
    logic [31:0]   m_req;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_keff = 0; m_served = 0; m_ovf = 1'b0; m_req = '0; m_data = '0;
        m_q.delete();
    endtask

    task automatic model_arm();
        m_keff   = (bus.k_in > 16'(MK)) ? MK : int'(bus.k_in);
        m_served = 0;
        m_ovf    = 1'b0;
        m_q.delete();
        m_mode   = (m_keff == 0) ? 2 : 1;
    endtask

    task automatic model_update();
        bit p;
        p = (bus.host_req_in != m_req) && (bus.host_req_in == 32'd1);
        m_req = bus.host_req_in;
        case (m_mode)
            0: if (bus.start_in) model_arm();
            1: if (bus.result_valid_in) begin
                m_q.push_back(bus.result_in);
                if (m_q.size() == m_keff) begin
                    m_mode = 2; m_served = 0; m_data = m_q[0];
                end
            end
            default: if (bus.start_in) model_arm();
            else begin
                if (bus.result_valid_in) m_ovf = 1'b1;
                if (p && m_served < m_q.size()) begin
                    m_served++;
                    if (m_served < m_q.size()) m_data = m_q[m_served];
                end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 64'(bus.count_out), 64'(m_q.size()));
        check({tag, ".done"}, 64'(bus.done_out), 64'(m_mode == 2));
        check({tag, ".valid"}, 64'(bus.data_valid_out), 64'(m_mode == 2 && m_served < m_q.size()));
        check({tag, ".data"}, 64'(bus.data_out), 64'(m_data));
        check({tag, ".ovf"}, 64'(bus.overflow_out), 64'(m_ovf));
    endtask

    // One clock: model sees the same inputs the DUT samples; pulses drop afterwards.
    task automatic step(input string tag);
        @(posedge clk_in);
        model_update();
        #1;
        check_all(tag);
        bus.start_in = 1'b0;
        bus.result_valid_in = 1'b0;
    endtask

    task automatic do_start(input int k);
        bus.start_in = 1'b1; bus.k_in = 16'(k); step("start");
    endtask

    task automatic push(input logic [DW-1:0] v);
        bus.result_in = v; bus.result_valid_in = 1'b1; step("push");
    endtask

    task automatic host_pop();
        bus.host_req_in = 32'd1; step("pop1");
        bus.host_req_in = 32'd0; step("pop0");
    endtask

    initial begin
        rst_in = 1'b0;
        bus.start_in = 1'b0; bus.k_in = '0; bus.result_in = '0;
        bus.result_valid_in = 1'b0; bus.host_req_in = '0;
        model_reset();
        #2;
        check_all("reset");
        #10 rst_in = 1'b1;

        // Basic capture of four words, then served in order.
        do_start(4);
        push(5); push(7); push(1); push(9);
        check("t1.done", 64'(bus.done_out), 64'd1);
        check("t1.count", 64'(bus.count_out), 64'd4);
        check("t1.data", 64'(bus.data_out), 64'd5);
        host_pop(); check("t2.data7", 64'(bus.data_out), 64'd7);
        host_pop(); check("t2.data1", 64'(bus.data_out), 64'd1);
        host_pop(); check("t2.data9", 64'(bus.data_out), 64'd9);
        host_pop(); check("t2.valid", 64'(bus.data_valid_out), 64'd0);
        host_pop(); check("t2.hold", 64'(bus.data_out), 64'd9);
        check("t2.done", 64'(bus.done_out), 64'd1);

        // A held level counts once; 1->2->1 counts again.
        do_start(3);
        push(11); push(22); push(33);
        bus.host_req_in = 32'd1;
        repeat (10) step("held");
        check("t3.one_pop", 64'(bus.data_out), 64'd22);
        bus.host_req_in = 32'd2; step("req2");
        bus.host_req_in = 32'd1; step("req21");
        check("t3.second_pop", 64'(bus.data_out), 64'd33);
        bus.host_req_in = 32'd0; step("req0");

        // Requested count above depth saturates; extra words overflow.
        do_start(20);
        for (int i = 1; i <= 10; i++) push(DW'(i));
        check("t4.count", 64'(bus.count_out), 64'd8);
        check("t4.ovf", 64'(bus.overflow_out), 64'd1);
        do_start(3);
        check("t4.ovf_clr", 64'(bus.overflow_out), 64'd0);

        // Asynchronous reset in the middle of a collection.
        push(100); push(101);
        rst_in = 1'b0;
        model_reset();
        #2;
        check_all("t5.rst");
        check("t5.count0", 64'(bus.count_out), 64'd0);
        @(negedge clk_in) rst_in = 1'b1;
        do_start(2);
        push(3); push(4);
        check("t5.data", 64'(bus.data_out), 64'd3);
        check("t5.count", 64'(bus.count_out), 64'd2);

        // Zero-length search, then a stray result.
        do_start(0);
        check("t6.done", 64'(bus.done_out), 64'd1);
        check("t6.valid", 64'(bus.data_valid_out), 64'd0);
        push(55);
        check("t6.ovf", 64'(bus.overflow_out), 64'd1);

        // Single-word search: head is the word just written.
        do_start(1);
        push(77);
        check("k1.data", 64'(bus.data_out), 64'd77);
        check("k1.valid", 64'(bus.data_valid_out), 64'd1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.start_in        = ($urandom_range(0, 19) == 0);
            bus.k_in            = 16'($urandom_range(0, 11));
            bus.result_valid_in = $urandom_range(0, 1) == 1;
            bus.result_in       = $urandom;
            case ($urandom_range(0, 4))
                0:       bus.host_req_in = 32'd0;
                1, 2:    bus.host_req_in = 32'd1;
                3:       bus.host_req_in = 32'd2;
                default: bus.host_req_in = $urandom;
            endcase
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
